// File: rtl/alu_serial_deser.sv
// Serial input stage of the ALU: parses 11-bit packets into an operand/opcode frame.
// Optional CRC checking is built when ALU_DESER_CRC_CHECK_EN is defined.
module alu_serial_deser #(
  parameter int N_DATA = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sin,
  output logic                out_valid,
  output logic [4*N_DATA-1:0] a,
  output logic [4*N_DATA-1:0] b,
  output logic [2:0]          op,
  output logic [2:0]          err_flags
);

  localparam int SH_W  = 8 * N_DATA;
  localparam int HW    = 4 * N_DATA;
  localparam int CNT_W = $clog2(N_DATA + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP,
    S_RESYNC
  } state_t;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  localparam logic [2:0] ERR_DATA = 3'b100;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_OP   = 3'b001;

  state_t           r_state;
  logic [2:0]       r_bit_cnt;
  logic             r_is_cmd;
  logic [7:0]       r_payload;
  logic [SH_W-1:0]  r_shreg;
  logic [CNT_W-1:0] r_data_cnt;
  logic             r_out_valid;
  logic [HW-1:0]    r_a;
  logic [HW-1:0]    r_b;
  logic [2:0]       r_op;
  logic [2:0]       r_err;

  logic [2:0]       w_cmd_op;
  logic             w_cnt_ok;
  logic             w_crc_ok;
  logic             w_op_ok;
  logic             w_unused_bits;

  function automatic logic op_is_valid(input logic [2:0] o);
    case (o)
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  assign w_cmd_op = r_payload[6:4];
  assign w_cnt_ok = (r_data_cnt == CNT_W'(N_DATA));
  assign w_op_ok  = op_is_valid(w_cmd_op);

`ifdef ALU_DESER_CRC_CHECK_EN
  logic [3:0] r_crc;
  logic [3:0] w_crc_calc;
  logic       w_data_done;
  logic       w_frame_clr;

  // One LFSR step of x^4+x+1, fed MSB first.
  function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic d);
    logic fb;
    fb = d ^ c[3];
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  function automatic logic [3:0] crc_byte(input logic [3:0] c, input logic [7:0] d);
    logic [3:0] n;
    n = c;
    for (int i = 7; i >= 0; i--) n = crc_bit(n, d[i]);
    return n;
  endfunction

  function automatic logic [3:0] crc_nib(input logic [3:0] c, input logic [3:0] d);
    logic [3:0] n;
    n = c;
    for (int i = 3; i >= 0; i--) n = crc_bit(n, d[i]);
    return n;
  endfunction

  assign w_data_done   = (r_state == S_STOP) && sin && !r_is_cmd;
  assign w_frame_clr   = (r_state == S_STOP) && (!sin || r_is_cmd);
  assign w_crc_calc    = crc_nib(r_crc, {1'b1, w_cmd_op});
  assign w_crc_ok      = (w_crc_calc == r_payload[3:0]);
  assign w_unused_bits = r_payload[7];

  // Running CRC over the DATA bytes of the current frame; the CMD tail is folded in combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_crc <= '0;
    else if (w_frame_clr) r_crc <= '0;
    else if (w_data_done) r_crc <= crc_byte(r_crc, r_payload);
  end
`else
  assign w_crc_ok      = 1'b1;
  assign w_unused_bits = ^{r_payload[7], r_payload[3:0]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_is_cmd    <= 1'b0;
      r_payload   <= '0;
      r_shreg     <= '0;
      r_data_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_err       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!sin) r_state <= S_TYPE;
        end
        S_TYPE: begin
          r_is_cmd  <= sin;
          r_bit_cnt <= '0;
          r_state   <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          r_payload <= {r_payload[6:0], sin};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= S_STOP;
        end
        S_STOP: begin
          if (!sin) begin
            // Framing lost: drop the frame and report it as a data error.
            r_out_valid <= 1'b1;
            r_err       <= ERR_DATA;
            r_data_cnt  <= '0;
            r_shreg     <= '0;
            r_state     <= S_RESYNC;
          end else begin
            r_state <= S_IDLE;
            if (r_is_cmd) begin
              r_out_valid <= 1'b1;
              r_a         <= r_shreg[HW-1:0];
              r_b         <= r_shreg[SH_W-1:HW];
              r_op        <= w_cmd_op;
              r_data_cnt  <= '0;
              if (!w_cnt_ok)      r_err <= ERR_DATA;
              else if (!w_crc_ok) r_err <= ERR_CRC;
              else if (!w_op_ok)  r_err <= ERR_OP;
              else                r_err <= 3'b000;
            end else begin
              r_shreg <= {r_shreg[SH_W-9:0], r_payload};
              if (r_data_cnt != CNT_W'(N_DATA + 1)) r_data_cnt <= r_data_cnt + CNT_W'(1);
            end
          end
        end
        S_RESYNC: begin
          if (sin) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign a         = r_a;
  assign b         = r_b;
  assign op        = r_op;
  assign err_flags = r_err;

endmodule

// File: doc/alu_serial_deser.md
# alu_serial_deser

Upstream input stage of the serial ALU. Watches the single-bit `sin` line and parses 11-bit packets into one operation frame: eight DATA bytes (B then A, most significant byte first) and one CMD byte. It checks framing, packet count, CRC and opcode, then presents `a`, `b`, `op` and error flags to the ALU core with a one-cycle `out_valid` pulse.

## Interface
- `N_DATA`, default 8: DATA packets per frame. Must be even. `a` and `b` are each `4*N_DATA` bits wide; ALU use requires 8.
- `clk` in 1: single clock. `sin` is synchronous to it and carries one bit per cycle.
- `rst_n` in 1: asynchronous, active-low reset.
- `sin` in 1: serial input. Idles high.
- `out_valid` out 1: one-cycle pulse marking a completed frame or a frame error.
- `a` out `4*N_DATA`: operand A.
- `b` out `4*N_DATA`: operand B.
- `op` out 3: opcode, using `operation_t` encoding.
- `err_flags` out 3: `{ERR_DATA, ERR_CRC, ERR_OP}`. At most one bit is set.

## Operation
- **Packet format** (LSB-first timeline): start bit `0`, type bit (`0` = DATA, `1` = CMD), 8 payload bits sent MSB first, stop bit `1`.
- **Bit FSM states:**
  - `IDLE`: go to `TYPE` when `sin == 0`.
  - `TYPE`: capture the type bit.
  - `PAYLOAD`: 8 cycles, counted by a 3-bit counter.
  - `STOP`: check the stop bit, then go back to `IDLE`.
  - `RESYNC`: wait until `sin == 1`, then go to `IDLE`.
- **Frame level:**
  - Each DATA packet shifts into a `8*N_DATA`-bit register, giving `{B,A}` with B first.
  - A data counter counts DATA packets and saturates at `N_DATA+1`.
- **On a CMD packet with a good stop bit:**
  - The payload is `{1'b0, op[2:0], crc[3:0]}`.
  - Evaluate errors in priority order:
    1. Data counter ≠ `N_DATA`: `ERR_DATA`.
    2. Otherwise, CRC mismatch: `ERR_CRC`.
    3. Otherwise, `op` not in {000, 001, 100, 101}: `ERR_OP`.
    4. Otherwise, no error.
  - Pulse `out_valid`, then clear the data counter.
- **Bad stop bit** (`sin == 0` in `STOP`), on any packet type:
  - Discard the frame and clear the data counter.
  - Pulse `out_valid` with `err_flags = 3'b100`.
  - Enter `RESYNC`.
- **CRC:**
  - LFSR x⁴+x+1, initial value `4'b0000`.
  - Input bits, MSB first: B[31..0], A[31..0], `1'b1`, op[2:0].
  - Update rule per bit `d`:
    - `c0' = d ^ c3`
    - `c1' = c0 ^ d ^ c3`
    - `c2' = c1`
    - `c3' = c2`
- **Outputs:**
  - `a`, `b`, `op` are registered and hold their values between pulses.
  - When any error flag is set, their contents are don't-care.

## Timing
- **Reset values:**
  - `out_valid = 0`, `a = 0`, `b = 0`, `op = 3'b000`, `err_flags = 3'b000`.
  - Bit FSM goes to `IDLE`; data counter = 0; shift register = 0.
- **Latency:** `out_valid` rises in the cycle after the stop bit (or bad stop bit) is sampled. It stays high for exactly one cycle.
- **Back-to-back packets:** a start bit may arrive in the cycle directly after a stop bit and must be accepted. The sustained rate is one packet per 11 cycles.
- **No backpressure:** the consumer must accept every pulse. Pulses are at least 11 cycles apart.
- **Reset mid-packet or mid-frame:** everything is cleared immediately. A pulse in flight is cancelled. The next `sin == 0` after reset is treated as a start bit.
- **Data-count boundary:**
  - More than `N_DATA` DATA packets: the counter saturates, and the next CMD reports `ERR_DATA`.
  - A CMD after fewer than `N_DATA` DATA packets: `ERR_DATA`.
  - The shift register keeps only the last `N_DATA` bytes.
- **Timeout:** none. A frame may stall between packets indefinitely.

## Configuration
- `ALU_DESER_CRC_CHECK_EN`:
  - Defined: the CRC is computed and compared, and a mismatch sets `ERR_CRC`.
  - Undefined: no CRC logic is built, the received CRC nibble is ignored, and `ERR_CRC` is always 0. `ERR_DATA` and `ERR_OP` priority is unchanged.

## Test plan
- **Valid AND frame.** Stimulus: 8 DATA packets of `0x00`, then CMD `0x0B` (op 000, CRC 1011). Required: one-cycle `out_valid`, `a = b = 0`, `op = 000`, `err_flags = 000`, rising 1 cycle after the CMD stop bit.
- **CRC error.** Stimulus: same frame with CMD `0x0A`. Required: `err_flags = 010`, or `000` when the macro is undefined.
- **Short frame.** Stimulus: 7 DATA packets, then CMD `0x0B`. Required: `err_flags = 100`. A following correct 8+1 frame then gives `err_flags = 000`.
- **Invalid opcode.** Stimulus: 8 DATA packets of `0x00` with op `010`, and CRC computed per the rule above. Required: `err_flags = 001`.
- **Bad stop bit.** Stimulus: `sin` held 0 on the 3rd DATA packet's stop bit and for 5 more cycles, then high. Required: `err_flags = 100` 1 cycle after the bad stop bit, no further pulses while `sin` is low, and the next full frame is decoded correctly.
- **Reset mid-frame.** Stimulus: `rst_n` pulsed low during the 5th DATA packet. Required: all outputs at reset values, no pulse, and the next full frame with `A = 0x01020304`, `B = 0x05060708`, `op = 100` is decoded correctly.
